// File: rtl/countdown_timer_ctrl.sv
// Two-digit BCD countdown timer controller: load / run / pause / alarm sequencing.
// Optional periodic mode: define AUTO_RELOAD_EN to restart from the last load after ALARM.
module countdown_timer_ctrl #(
  parameter int unsigned ALARM_CYCLES = 4,
  parameter int unsigned TENS_MAX     = 9
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;
  localparam logic [1:0] StAlarm = 2'b11;

  localparam logic [3:0] TensMax   = 4'(TENS_MAX);
  localparam logic [7:0] AlarmLast = 8'(ALARM_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [7:0] acnt_q, acnt_d;
  logic       done_q, done_d;
  logic       busy_q, alarm_q;
  logic [3:0] ld_tens, ld_ones;
  logic       nonzero;

`ifdef AUTO_RELOAD_EN
  logic [7:0] reload_q, reload_d;
`endif

  always_comb begin
    ld_tens = (load_val[7:4] > TensMax) ? TensMax : load_val[7:4];
    ld_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
    nonzero = (tens_q != 4'd0) || (ones_q != 4'd0);
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      StIdle: begin
        if (load) begin
          tens_d = ld_tens;
          ones_d = ld_ones;
`ifdef AUTO_RELOAD_EN
          reload_d = {ld_tens, ld_ones};
`endif
        end else if (start && nonzero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (pause) begin
          state_d = StPause;
        end else if (tick) begin
          if (tens_q == 4'd0 && ones_q == 4'd1) begin
            ones_d  = 4'd0;
            state_d = StAlarm;
            acnt_d  = 8'd0;
            done_d  = 1'b1;
          end else if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else if (tens_q != 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
        end
      end
      StPause: begin
        if (load) begin
          tens_d = ld_tens;
          ones_d = ld_ones;
`ifdef AUTO_RELOAD_EN
          reload_d = {ld_tens, ld_ones};
`endif
        end else if (start) begin
          state_d = nonzero ? StRun : StIdle;
        end
      end
      default: begin
        // Alarm length is counted in clk cycles; tick and keys have no effect here.
        if (acnt_q == AlarmLast) begin
`ifdef AUTO_RELOAD_EN
          tens_d  = reload_q[7:4];
          ones_d  = reload_q[3:0];
          state_d = (reload_q != 8'd0) ? StRun : StIdle;
`else
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = StIdle;
`endif
        end else begin
          acnt_d = acnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q <= StIdle;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      acnt_q  <= 8'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d == StRun) || (state_d == StPause);
      alarm_q <= (state_d == StAlarm);
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q_tens = tens_q;
  assign q_ones = ones_q;
  assign state  = state_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign alarm  = alarm_q;

endmodule
